// File: rtl/seq_tx_pkg.sv
// Shared encodings and constants for the seq_tx serializer.
// The preamble constant and PRE state exist only when SEQ_TX_PREAMBLE_EN is defined.
package seq_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
`ifdef SEQ_TX_PREAMBLE_EN
    localparam logic [1:0] ST_PRE  = 2'b01;
    localparam logic [3:0] PREAMBLE = 4'b1001;
`endif
    localparam logic [1:0] ST_DATA = 2'b10;
    localparam logic [1:0] ST_GAP  = 2'b11;

    localparam int PRE_LEN = 4;

    // Counter spans the longer of payload and preamble, plus one for the terminal value.
    function automatic int cnt_width(input int data_w);
        int span;
        span = (data_w > PRE_LEN) ? data_w : PRE_LEN;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/seq_tx_if.sv
// Producer-side handshake and serial line outputs of seq_tx.
interface seq_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              ready;
    logic              out;
    logic              busy;
    logic              done;

    modport master (output data_in, valid, input ready, out, busy, done);
    modport slave  (input data_in, valid, output ready, out, busy, done);
endinterface

// File: rtl/tx_shift_reg.sv
// Load/shift datapath feeding the serial line MSB first.
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              msb
);
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[DATA_W-1];
endmodule

// File: rtl/seq_tx.sv
// Framed serial transmitter: handshake in, registered MSB-first bit stream out.
// Define SEQ_TX_PREAMBLE_EN to prefix every frame with the 1001 preamble.
//
// state | meaning
// IDLE  | waiting for valid; ready high
// PRE   | driving preamble bits (preamble builds only)
// DATA  | driving payload bits MSB first
// GAP   | driving IDLE_BIT for GAP_LEN cycles
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   GAP_LEN  = 1,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic    clk,
    input logic    rst,
    seq_tx_if.slave bus
);
    localparam int CNT_W = cnt_width(DATA_W);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        gap_cnt;
    logic              out_bit;
    logic              done_bit;
    logic              accept;
    logic              shift;
    logic              msb;
    logic              cnt_zero;
    logic [DATA_W-1:0] load_word;

    assign bus.ready = (state == ST_IDLE) && !rst;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.out   = out_bit;
    assign bus.done  = done_bit;
    assign accept    = bus.valid && bus.ready;
    assign cnt_zero  = (cnt == '0);

`ifdef SEQ_TX_PREAMBLE_EN
    logic [1:0] pre_idx;
    assign pre_idx   = cnt[1:0] - 2'd1;
    assign load_word = bus.data_in;
    assign shift     = ((state == ST_PRE) && cnt_zero) || ((state == ST_DATA) && !cnt_zero);
`else
    // The MSB goes straight to the line at acceptance, so the register starts one bit ahead.
    assign load_word = bus.data_in << 1;
    assign shift     = (state == ST_DATA) && !cnt_zero;
`endif

    tx_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (load_word),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            out_bit  <= IDLE_BIT;
            done_bit <= 1'b0;
        end else begin
            done_bit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef SEQ_TX_PREAMBLE_EN
                        state   <= ST_PRE;
                        cnt     <= CNT_W'(PRE_LEN - 1);
                        out_bit <= PREAMBLE[3];
`else
                        state    <= ST_DATA;
                        cnt      <= CNT_W'(DATA_W - 1);
                        out_bit  <= bus.data_in[DATA_W-1];
                        done_bit <= (DATA_W == 1);
`endif
                    end
                end
`ifdef SEQ_TX_PREAMBLE_EN
                ST_PRE: begin
                    if (cnt_zero) begin
                        state    <= ST_DATA;
                        cnt      <= CNT_W'(DATA_W - 1);
                        out_bit  <= msb;
                        done_bit <= (DATA_W == 1);
                    end else begin
                        cnt     <= cnt - 1'b1;
                        out_bit <= PREAMBLE[pre_idx];
                    end
                end
`endif
                ST_DATA: begin
                    if (cnt_zero) begin
                        out_bit <= IDLE_BIT;
                        cnt     <= '0;
                        if (GAP_LEN == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= 4'(GAP_LEN - 1);
                        end
                    end else begin
                        cnt      <= cnt - 1'b1;
                        out_bit  <= msb;
                        done_bit <= (cnt == CNT_W'(1));
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: one instance with a gap, one back-to-back with GAP_LEN=0.
// Expected streams adapt to whether SEQ_TX_PREAMBLE_EN is defined.
module tb_seq_tx;
`ifdef SEQ_TX_PREAMBLE_EN
    localparam int PRE_OFF = 4;
`else
    localparam int PRE_OFF = 0;
`endif
    localparam int FLEN = PRE_OFF + 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_tx_if #(.DATA_W(8)) if_a ();
    seq_tx_if #(.DATA_W(8)) if_b ();

    seq_tx #(.DATA_W(8), .GAP_LEN(1), .IDLE_BIT(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    seq_tx #(.DATA_W(8), .GAP_LEN(0), .IDLE_BIT(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one word on instance A and checks every cycle up to the return to IDLE.
    task automatic run_frame_a(input string tag, input logic [7:0] word,
                               input logic [15:0] exp_bits, input bit noisy);
        @(negedge clk);
        if_a.valid   = 1'b1;
        if_a.data_in = word;
        #1 check_val({tag, "_ready_pre"}, 32'(if_a.ready), 32'd1);
        @(negedge clk);
        if_a.valid = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            check_val({tag, "_out"},  32'(if_a.out),  32'(exp_bits[FLEN-i]));
            check_val({tag, "_done"}, 32'(if_a.done), 32'(i == FLEN));
            check_val({tag, "_busy"}, 32'(if_a.busy), 32'd1);
            if (noisy) begin
                if_a.valid   = i[0];
                if_a.data_in = 8'($urandom);
            end
            @(negedge clk);
        end
        if_a.valid = 1'b0;
        check_val({tag, "_gap_out"},   32'(if_a.out),   32'd0);
        check_val({tag, "_gap_busy"},  32'(if_a.busy),  32'd1);
        check_val({tag, "_gap_ready"}, 32'(if_a.ready), 32'd0);
        check_val({tag, "_gap_done"},  32'(if_a.done),  32'd0);
        @(negedge clk);
        check_val({tag, "_idle_ready"}, 32'(if_a.ready), 32'd1);
        check_val({tag, "_idle_busy"},  32'(if_a.busy),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] det_st;
        logic       det_out;
        int         done_cnt;
        int         idle_cnt;

        rst          = 1'b1;
        if_a.valid   = 1'b0;
        if_a.data_in = '0;
        if_b.valid   = 1'b0;
        if_b.data_in = '0;

        repeat (3) @(negedge clk);
        check_val("rst_ready_a", 32'(if_a.ready), 32'd0);
        check_val("rst_ready_b", 32'(if_b.ready), 32'd0);
        check_val("rst_out_a",   32'(if_a.out),   32'd0);
        check_val("rst_out_b",   32'(if_b.out),   32'd1);
        check_val("rst_busy_a",  32'(if_a.busy),  32'd0);
        check_val("rst_done_a",  32'(if_a.done),  32'd0);
        rst = 1'b0;
        #1 check_val("rel_ready_a", 32'(if_a.ready), 32'd1);
        check_val("rel_ready_b", 32'(if_b.ready), 32'd1);

`ifdef SEQ_TX_PREAMBLE_EN
        run_frame_a("a5", 8'hA5, 16'b0000_1001_1010_0101, 1'b0);
        run_frame_a("3c", 8'h3C, 16'b0000_1001_0011_1100, 1'b0);
        run_frame_a("noisy", 8'h5A, 16'b0000_1001_0101_1010, 1'b1);
`else
        run_frame_a("a5", 8'hA5, 16'h00A5, 1'b0);
        run_frame_a("3c", 8'h3C, 16'h003C, 1'b0);
        run_frame_a("noisy", 8'h5A, 16'h005A, 1'b1);
`endif

        // Reset while payload bit 3 of 8'h4C (a one) is on the line.
        @(negedge clk);
        if_a.valid   = 1'b1;
        if_a.data_in = 8'h4C;
        @(negedge clk);
        if_a.valid = 1'b0;
        repeat (PRE_OFF + 4) @(negedge clk);
        check_val("mid_bit3", 32'(if_a.out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_out",   32'(if_a.out),   32'd0);
        check_val("mid_rst_busy",  32'(if_a.busy),  32'd0);
        check_val("mid_rst_done",  32'(if_a.done),  32'd0);
        check_val("mid_rst_ready", 32'(if_a.ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("post_rst_ready", 32'(if_a.ready), 32'd1);
            check_val("post_rst_done",  32'(if_a.done),  32'd0);
            check_val("post_rst_out",   32'(if_a.out),   32'd0);
        end

`ifdef SEQ_TX_PREAMBLE_EN
        // Loopback into a 1001 Mealy detector model.
        det_st = 2'd0;
        @(negedge clk);
        if_a.valid   = 1'b1;
        if_a.data_in = 8'h00;
        @(negedge clk);
        if_a.valid = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            det_out = (det_st == 2'd3) && if_a.out;
            check_val("det_out", 32'(det_out), 32'(i == 4));
            case (det_st)
                2'd0:    det_st = if_a.out ? 2'd1 : 2'd0;
                2'd1:    det_st = if_a.out ? 2'd1 : 2'd2;
                2'd2:    det_st = if_a.out ? 2'd1 : 2'd3;
                default: det_st = if_a.out ? 2'd1 : 2'd0;
            endcase
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
`endif

        // Back-to-back frames on the GAP_LEN=0 instance.
        done_cnt = 0;
        idle_cnt = 0;
        @(negedge clk);
        if_b.valid   = 1'b1;
        if_b.data_in = 8'hFF;
        @(negedge clk);
        if_b.data_in = 8'h01;
        for (int c = 1; c <= 2 * FLEN + 3; c++) begin
            check_val("b2b_busy", 32'(if_b.busy), 32'(!((c == FLEN + 1) || (c >= 2 * FLEN + 2))));
            check_val("b2b_done", 32'(if_b.done), 32'((c == FLEN) || (c == 2 * FLEN + 1)));
            if (c == FLEN + 1) begin
                check_val("b2b_idle_out",   32'(if_b.out),   32'd1);
                check_val("b2b_idle_ready", 32'(if_b.ready), 32'd1);
            end
            if (c == 2 * FLEN)     check_val("b2b_bit1", 32'(if_b.out), 32'd0);
            if (c == 2 * FLEN + 1) check_val("b2b_bit0", 32'(if_b.out), 32'd1);
            if (if_b.done) done_cnt++;
            if (c <= 2 * FLEN + 1 && !if_b.busy) idle_cnt++;
            if (c == 2 * FLEN + 1) if_b.valid = 1'b0;
            @(negedge clk);
        end
        check_val("b2b_done_count", 32'(done_cnt), 32'd2);
        check_val("b2b_idle_count", 32'(idle_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
